// File: rtl/base_core_defines.sv
// Shared definitions for the base core: ISA constants, enable levels and
// the instruction-fetch FSM encodings.
package base_core_defines;

  localparam int WORD_DATA_W = 32;
  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [0:0] {
    IF_ST_RUN  = 1'b0,
    IF_ST_FULL = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_prefetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with clear; head is visible combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module if_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only entries covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a DEPTH-entry prefetch FIFO and a pipelined
// req/gnt/rvalid memory port. Define IF_BYPASS_EN to let a response go straight
// into IF/ID when the FIFO is empty and nothing is being discarded.
//
//   state      | meaning
//   IF_ST_RUN  | requests allowed while fifo_count + outstanding < DEPTH
//   IF_ST_FULL | every slot reserved by FIFO data or in-flight fetches
module if_prefetch_stage
  import base_core_defines::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = DATA_W + ADDR_W;
  localparam logic [CNT_W:0]      DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0]   NOP     = DATA_W'(ISA_NOP);
  localparam logic [ADDR_W-1:0]   STEP    = ADDR_W'(32'd4);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d, mem_req_q, mem_req_d;
  logic [CNT_W-1:0]  outst_q, outst_d, discard_q, discard_d;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_d;
  logic [CNT_W:0]    inflight_d;
  logic              fifo_empty, fifo_full;
  logic [ENT_W-1:0]  fifo_head, fifo_wdata;
  logic              redirect, gnt_acc, rsp_acc, drop, bypass, push, pop;
  logic [ADDR_W-1:0] target;

  assign redirect = flush || br_taken;
  assign target   = flush ? new_pc : br_addr;
  assign gnt_acc  = mem_req_q && mem_gnt;
  assign rsp_acc  = mem_rvalid && (outst_q != '0);
  assign drop     = rsp_acc && (discard_q != '0);
  assign pop      = !stall && !redirect && !fifo_empty;

`ifdef IF_BYPASS_EN
  assign bypass = rsp_acc && !drop && fifo_empty && !stall && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign push       = rsp_acc && !drop && !bypass && !redirect && (!fifo_full || pop);
  // rsp_pc_q tracks the address of the next response that will be kept.
  assign fifo_wdata = {mem_rd_data, rsp_pc_q + STEP};

  if_prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk     (clk),
    .reset_  (reset_),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    if_pc_d    = if_pc_q;
    if_insn_d  = if_insn_q;
    if_en_d    = if_en_q;
    outst_d    = outst_q + CNT_W'(gnt_acc) - CNT_W'(rsp_acc);
    discard_d  = drop ? discard_q - 1'b1 : discard_q;
    fifo_cnt_d = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    if (gnt_acc) pc_d = pc_q + STEP;
    if (rsp_acc && !drop) rsp_pc_d = rsp_pc_q + STEP;

    if (redirect) begin
      pc_d       = target;
      rsp_pc_d   = target;
      if_pc_d    = target;
      if_insn_d  = NOP;
      if_en_d    = DISABLE;
      discard_d  = outst_d;
      fifo_cnt_d = '0;
    end else if (!stall) begin
      if (pop) begin
        if_insn_d = fifo_head[ENT_W-1 -: DATA_W];
        if_pc_d   = fifo_head[ADDR_W-1:0];
        if_en_d   = ENABLE;
      end else if (bypass) begin
        if_insn_d = mem_rd_data;
        if_pc_d   = rsp_pc_q + STEP;
        if_en_d   = ENABLE;
      end else begin
        if_insn_d = NOP;
        if_en_d   = DISABLE;
      end
    end

    inflight_d = {1'b0, fifo_cnt_d} + {1'b0, outst_d};
    case (state_q)
      IF_ST_RUN:  if (inflight_d == DEPTH_C) state_d = IF_ST_FULL;
      IF_ST_FULL: if (inflight_d <  DEPTH_C) state_d = IF_ST_RUN;
      default:    state_d = IF_ST_RUN;
    endcase
    if (redirect) state_d = IF_ST_RUN;
    mem_req_d = (state_d == IF_ST_RUN) && (inflight_d < DEPTH_C);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= IF_ST_RUN;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      if_pc_q   <= RESET_PC;
      if_insn_q <= NOP;
      if_en_q   <= DISABLE;
      mem_req_q <= DISABLE;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      if_pc_q   <= if_pc_d;
      if_insn_q <= if_insn_d;
      if_en_q   <= if_en_d;
      mem_req_q <= mem_req_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q[ADDR_W-1:2];
  assign pc       = pc_q;
  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
  assign if_en    = if_en_q;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a latency-1 in-order memory slave
// returns {addr,2'b00} + 0x128 for every granted word address.
module tb_if_prefetch_stage;
  import base_core_defines::*;

`ifdef IF_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [31:0] new_pc = '0, br_addr = '0;
  logic [31:0] pc, if_pc, if_insn;
  logic        if_en;

  logic [29:0] rsp_q[$];
  bit          gnt_en, rsp_hold;
  int          n_grant, n_checks, n_pass;
  int          cyc;
  bit          found;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk(clk), .reset_(reset_),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rd_data(mem_rd_data),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr),
    .pc(pc), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Advance to the next falling edge and play the memory slave for the coming rise.
  task automatic step();
    logic [29:0] a;
    @(negedge clk);
    if (!rsp_hold && rsp_q.size() > 0) begin
      a = rsp_q.pop_front();
      mem_rvalid  = 1'b1;
      mem_rd_data = {a, 2'b00} + 32'h128;
    end else begin
      mem_rvalid  = 1'b0;
      mem_rd_data = '0;
    end
    mem_gnt = gnt_en;
    if (mem_req && mem_gnt) begin
      rsp_q.push_back(mem_addr);
      n_grant++;
    end
  endtask

  task automatic apply_reset();
    reset_ = 1'b0;
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0; new_pc = '0; br_addr = '0;
    gnt_en = 1'b1; rsp_hold = 1'b0; rsp_q.delete(); n_grant = 0;
    repeat (2) step();
  endtask

  task automatic wait_en(input string tag, input int limit);
    found = 1'b0;
    cyc = 0;
    for (int i = 1; i <= limit && !found; i++) begin
      step();
      if (if_en) begin
        found = 1'b1;
        cyc = i;
      end
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;

    // Reset values and first deliveries
    apply_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_insn", if_insn, ISA_NOP);
    chk("rst_if_en", 64'(if_en), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    reset_ = 1'b1;
    wait_en("first_en_seen", 10);
    chk("first_latency", 64'(cyc), 64'(LAT));
    chk("first_insn", if_insn, 32'h128);
    chk("first_if_pc", if_pc, 32'h4);
    step();
    chk("second_en", 64'(if_en), 64'd1);
    chk("second_insn", if_insn, 32'h12C);
    chk("second_if_pc", if_pc, 32'h8);

    // Stall fills exactly DEPTH slots, then four back-to-back deliveries
    apply_reset();
    stall = 1'b1;
    reset_ = 1'b1;
    repeat (8) step();
    chk("stall_grants", 64'(n_grant), 64'd4);
    chk("stall_mem_req", 64'(mem_req), 64'd0);
    chk("stall_state", 64'(dut.state_q), 64'(IF_ST_FULL));
    chk("stall_if_en", 64'(if_en), 64'd0);
    chk("stall_if_pc", if_pc, 32'h0);
    chk("stall_if_insn", if_insn, ISA_NOP);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_en", 64'(if_en), 64'd1);
      chk("drain_if_pc", if_pc, 32'(4 * (i + 1)));
      chk("drain_insn", if_insn, 32'(4 * i + 32'h128));
    end

    // Flush with two responses outstanding
    apply_reset();
    rsp_hold = 1'b1;
    reset_ = 1'b1;
    step();
    step();
    gnt_en = 1'b0;
    step();
    chk("pre_flush_outst", 64'(dut.outst_q), 64'd2);
    flush = 1'b1;
    new_pc = 32'h160;
    step();
    flush = 1'b0;
    chk("flush_if_pc", if_pc, 32'h160);
    chk("flush_if_en", 64'(if_en), 64'd0);
    chk("flush_pc", pc, 32'h160);
    chk("flush_if_insn", if_insn, ISA_NOP);
    rsp_hold = 1'b0;
    gnt_en = 1'b1;
    wait_en("flush_en_seen", 12);
    chk("flush_first_if_pc", if_pc, 32'h164);
    chk("flush_first_insn", if_insn, 32'h288);

    // Flush beats branch, redirect beats stall; then a plain branch
    apply_reset();
    reset_ = 1'b1;
    step();
    step();
    flush = 1'b1; new_pc = 32'h160;
    br_taken = 1'b1; br_addr = 32'h128;
    stall = 1'b1;
    step();
    flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
    chk("prio_pc", pc, 32'h160);
    chk("prio_if_pc", if_pc, 32'h160);
    chk("prio_if_en", 64'(if_en), 64'd0);
    br_taken = 1'b1; br_addr = 32'h128;
    step();
    br_taken = 1'b0;
    chk("br_pc", pc, 32'h128);
    chk("br_if_pc", if_pc, 32'h128);
    wait_en("br_en_seen", 12);
    chk("br_first_if_pc", if_pc, 32'h12C);
    chk("br_first_insn", if_insn, 32'h250);

    // PC wrap at the top of the address space
    apply_reset();
    reset_ = 1'b1;
    step();
    flush = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    chk("wrap_addr_top", 64'(mem_addr), 64'h3FFF_FFFF);
    chk("wrap_req", 64'(mem_req), 64'd1);
    step();
    chk("wrap_pc_zero", pc, 32'h0);
    chk("wrap_addr_zero", 64'(mem_addr), 64'h0);
    wait_en("wrap_en_seen", 8);
    chk("wrap_if_pc", if_pc, 32'h0);
    chk("wrap_insn", if_insn, 32'h124);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
